// File: rtl/pes_pkg.sv
// pes_pkg: shared constants, FSM state type and saturating signed add for the egress scheduler
package pes_pkg;
  localparam int PES_NUM_TC = 8;
  localparam int PES_LEN_W  = 14;
  localparam int PES_QNT_W  = 16;

  typedef enum logic {IDLE, OFFER} pes_state_e;

  function automatic logic signed [63:0] sat_add_signed(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s, mx, mn;
    s  = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    return (s > mx) ? mx : (s < mn) ? mn : s;
  endfunction
endpackage

// File: rtl/pes_rr_next.sv
// pes_rr_next: wrap-around find-next-set search starting at ptr+1 over an N-bit mask
module pes_rr_next import pes_pkg::*; #(
  parameter  int N  = PES_NUM_TC,
  localparam int TW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [TW-1:0] ptr,
  output logic [TW-1:0] nxt,
  output logic          hit
);
  logic [TW-1:0] j;

  assign hit = |mask;

  // scan from farthest to nearest so the first set bit after ptr wins; ptr itself is last
  always_comb begin
    nxt = ptr;
    j   = ptr;
    for (int k = N; k >= 1; k--) begin
      j   = TW'((int'(ptr) + k) % N);
      nxt = mask[j] ? j : nxt;
    end
  end
endmodule

// File: rtl/pes_dwrr.sv
// pes_dwrr: strict-priority plus DWRR egress scheduler for one port; define PES_PFC_EN to add pfc_xoff gating
module pes_dwrr import pes_pkg::*; #(
  parameter  int NUM_TC = PES_NUM_TC,
  parameter  int LEN_W  = PES_LEN_W,
  parameter  int QNT_W  = PES_QNT_W,
  parameter  int DEF_W  = QNT_W + 2,
  localparam int TW     = $clog2(NUM_TC)
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NUM_TC-1:0]       epb_pkt_vld,
  input  logic [NUM_TC*LEN_W-1:0] epb_pkt_len,
  output logic [NUM_TC-1:0]       epb_deq,
  input  logic [NUM_TC-1:0]       lcm_xoff,
`ifdef PES_PFC_EN
  input  logic [NUM_TC-1:0]       pfc_xoff,
`endif
  input  logic [NUM_TC-1:0]       cfg_sp_mask,
  input  logic [NUM_TC*QNT_W-1:0] cfg_quantum,
  output logic                    txc_sel_vld,
  output logic [TW-1:0]           txc_sel_tc,
  output logic [LEN_W-1:0]        txc_sel_len,
  input  logic                    txc_sel_rdy
);
  pes_state_e              state;
  logic [TW-1:0]           ptr, nxt, sp_tc, pick;
  logic                    sel_sp, sp_any, dw_any, dw_hit, go, adv, chg;
  logic [NUM_TC-1:0]       elig, sp_elig, dw_elig, qnz;
  logic signed [DEF_W-1:0] deficit [NUM_TC];
  logic signed [DEF_W-1:0] def_n   [NUM_TC];

`ifdef PES_PFC_EN
  assign elig = epb_pkt_vld & ~lcm_xoff & ~pfc_xoff;
`else
  assign elig = epb_pkt_vld & ~lcm_xoff;
`endif

  for (genvar i = 0; i < NUM_TC; i++) begin : g_q
    assign qnz[i] = |cfg_quantum[i*QNT_W +: QNT_W];
  end

  assign sp_elig     = elig & cfg_sp_mask;
  assign dw_elig     = elig & ~cfg_sp_mask & qnz;
  assign sp_any      = |sp_elig;
  assign dw_hit      = dw_elig[ptr] & ~deficit[ptr][DEF_W-1] & (|deficit[ptr]);
  assign go          = sp_any | dw_hit;
  assign pick        = sp_any ? sp_tc : ptr;
  assign adv         = (state == IDLE) & ~go & dw_any;
  assign chg         = (state == OFFER) & txc_sel_rdy & ~sel_sp;
  assign txc_sel_vld = (state == OFFER);
  assign epb_deq     = (txc_sel_vld & txc_sel_rdy) ? (NUM_TC'(1) << txc_sel_tc) : '0;

  pes_rr_next #(.N(NUM_TC)) u_rr (
    .mask(dw_elig),
    .ptr (ptr),
    .nxt (nxt),
    .hit (dw_any)
  );

  // highest-index eligible strict-priority class
  always_comb begin
    sp_tc = '0;
    for (int i = 0; i < NUM_TC; i++) sp_tc = sp_elig[i] ? TW'(i) : sp_tc;
  end

  // charge a DWRR acceptance, refill the new pointer on advance, zero an emptied old pointer
  always_comb begin
    for (int i = 0; i < NUM_TC; i++)
      def_n[i] = (chg && TW'(i) == txc_sel_tc) ? DEF_W'(sat_add_signed(64'(deficit[i]), -64'(txc_sel_len), DEF_W))
               : (adv && TW'(i) == nxt) ? DEF_W'(sat_add_signed(64'(deficit[i]), 64'(cfg_quantum[i*QNT_W +: QNT_W]), DEF_W))
               : (adv && TW'(i) == ptr && !epb_pkt_vld[i]) ? '0
               : deficit[i];
  end

  // IDLE/OFFER control, committed offer latch, round-robin pointer and deficits
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      ptr         <= '0;
      sel_sp      <= 1'b0;
      txc_sel_tc  <= '0;
      txc_sel_len <= '0;
      deficit     <= '{default: '0};
    end else begin
      deficit <= def_n;
      if (state == IDLE && go) begin
        state       <= OFFER;
        txc_sel_tc  <= pick;
        txc_sel_len <= epb_pkt_len[pick*LEN_W +: LEN_W];
        sel_sp      <= sp_any;
      end else if (state == OFFER && txc_sel_rdy) begin
        state <= IDLE;
      end
      if (adv) ptr <= nxt;
    end
  end
endmodule

// File: tb/tb_pes_dwrr.sv
// tb_pes_dwrr: vector table, directed corner sequences and randomized run against a transaction-rule model
module tb_pes_dwrr;
  localparam int N  = 8;
  localparam int LW = 14;
  localparam int QW = 16;
  localparam int DW = QW + 2;

  logic          clk  = 1'b0;
  logic          arst = 1'b1;
  logic [N-1:0]  vld  = '0, xoff = '0, sp = '0, deq;
  logic [N*LW-1:0] lens = '0;
  logic [N*QW-1:0] q    = '0;
  logic          rdy  = 1'b0, ovld;
  logic [2:0]    otc;
  logic [LW-1:0] olen;
`ifdef PES_PFC_EN
  logic [N-1:0]  pfc = '0;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pes_dwrr dut (
    .clk        (clk),
    .arst       (arst),
    .epb_pkt_vld(vld),
    .epb_pkt_len(lens),
    .epb_deq    (deq),
    .lcm_xoff   (xoff),
`ifdef PES_PFC_EN
    .pfc_xoff   (pfc),
`endif
    .cfg_sp_mask(sp),
    .cfg_quantum(q),
    .txc_sel_vld(ovld),
    .txc_sel_tc (otc),
    .txc_sel_len(olen),
    .txc_sel_rdy(rdy)
  );

  typedef struct {
    logic [7:0] sp, vld, xoff;
    logic       ev;
    int         tc;
  } vec_t;
  vec_t tbl [8];

  bit      m_off, m_sp;
  int      m_tc, m_len, m_ptr;
  longint  m_def [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_len(input int i, input int v);
    lens[i*LW +: LW] = LW'(v);
  endtask

  task automatic set_q(input int i, input int v);
    q[i*QW +: QW] = QW'(v);
  endtask

  function automatic longint len_of(input int i);
    return longint'(lens[i*LW +: LW]);
  endfunction

  function automatic longint q_of(input int i);
    return longint'(q[i*QW +: QW]);
  endfunction

  function automatic longint clamp(input longint v);
    longint mx;
    mx = (longint'(1) <<< (DW - 1)) - 1;
    return (v > mx) ? mx : (v < -mx - 1) ? -mx - 1 : v;
  endfunction

  task automatic do_reset();
    arst = 1'b1;
    vld = '0; xoff = '0; sp = '0; lens = '0; q = '0; rdy = 1'b0;
`ifdef PES_PFC_EN
    pfc = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    m_off = 0; m_sp = 0; m_tc = 0; m_len = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_def[i] = 0;
  endtask

  task automatic wait_deq(input int budget, output logic [N-1:0] d);
    d = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (deq != '0) begin
        d = deq;
        return;
      end
    end
  endtask

  // one scheduling decision per cycle, written from the arbitration rules
  task automatic model_step();
    logic [N-1:0] el, spe, dw;
    int j;
    if (m_off) begin
      if (rdy) begin
        if (!m_sp) m_def[m_tc] = clamp(m_def[m_tc] - longint'(m_len));
        m_off = 0;
      end
      return;
    end
    el  = vld & ~xoff;
    spe = el & sp;
    for (int i = 0; i < N; i++) dw[i] = el[i] & ~sp[i] & (q_of(i) != 0);
    if (spe != '0) begin
      for (int i = 0; i < N; i++) if (spe[i]) m_tc = i;
      m_sp = 1; m_off = 1; m_len = int'(len_of(m_tc));
    end else if (dw != '0) begin
      if (dw[m_ptr] && m_def[m_ptr] > 0) begin
        m_tc = m_ptr; m_sp = 0; m_off = 1; m_len = int'(len_of(m_ptr));
      end else begin
        j = m_ptr;
        for (int k = 1; k <= N; k++) if (dw[(m_ptr + k) % N]) begin
          j = (m_ptr + k) % N;
          break;
        end
        if (!vld[m_ptr]) m_def[m_ptr] = 0;
        m_ptr = j;
        m_def[j] = clamp(m_def[j] + q_of(j));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] d;
    logic [31:0]  ex;
    int c0, c1, cnt;

    do_reset();
    #1;
    chk("reset_vld", ovld, 0);
    chk("reset_deq", deq, 0);
    chk("reset_tc", otc, 0);
    chk("reset_len", olen, 0);
    chk("reset_ptr", dut.ptr, 0);

    tbl[0] = '{8'h80, 8'h84, 8'h00, 1'b1, 7};
    tbl[1] = '{8'h84, 8'h84, 8'h00, 1'b1, 7};
    tbl[2] = '{8'h84, 8'h84, 8'h80, 1'b1, 2};
    tbl[3] = '{8'h00, 8'h04, 8'h00, 1'b0, 0};
    tbl[4] = '{8'hFF, 8'h00, 8'h00, 1'b0, 0};
    tbl[5] = '{8'h0F, 8'hFF, 8'h08, 1'b1, 2};
    tbl[6] = '{8'h01, 8'h03, 8'h00, 1'b1, 0};
    tbl[7] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 0};
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        set_q(i, 256);
        set_len(i, 10 + i);
      end
      sp = tbl[v].sp; vld = tbl[v].vld; xoff = tbl[v].xoff;
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_vld", v), ovld, tbl[v].ev);
      chk($sformatf("tbl%0d_tc", v), otc, tbl[v].tc);
      chk($sformatf("tbl%0d_len", v), olen, tbl[v].ev ? 10 + tbl[v].tc : 0);
    end

    do_reset();
    sp = 8'h80; vld = 8'h84; set_len(7, 64); set_len(2, 64); set_q(2, 256); rdy = 1'b1;
    @(negedge clk);
    #1;
    chk("sp_first_tc", otc, 7);
    chk("sp_first_deq", deq, 8'h80);
    vld = 8'h04;
    wait_deq(8, d);
    chk("sp_then_dwrr_deq", d, 8'h04);

    do_reset();
    vld = 8'h03; set_len(0, 100); set_len(1, 100); set_q(0, 300); set_q(1, 100); rdy = 1'b1;
    c0 = 0; c1 = 0;
    for (int c = 0; c < 400 && c0 + c1 < 40; c++) begin
      @(negedge clk);
      #1;
      if (deq[0]) c0++;
      if (deq[1]) c1++;
    end
    chk("ratio_total", c0 + c1, 40);
    chk("ratio_tc0_in_range", (c0 >= 29 && c0 <= 31), 1);

    do_reset();
    vld = 8'h01; set_len(0, 150); set_q(0, 100); rdy = 1'b1;
    @(negedge clk); #1;
    chk("carry_bubble", ovld, 0);
    @(negedge clk); #1;
    chk("carry_first_deq", deq, 8'h01);
    @(negedge clk); #1;
    chk("carry_def_neg", dut.deficit[0], -50);
    @(negedge clk); #1;
    chk("carry_def_pos", dut.deficit[0], 50);
    @(negedge clk); #1;
    chk("carry_second_offer", {ovld, otc, olen}, {1'b1, 3'd0, 14'd150});

    do_reset();
    sp = 8'h20; vld = 8'h20; set_len(5, 77);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) xoff = 8'h20;
      #1;
      chk("bp_hold", {ovld, otc, olen, deq}, {1'b1, 3'd5, 14'd77, 8'h00});
      @(negedge clk);
    end
    rdy = 1'b1;
    #1;
    chk("bp_accept_deq", deq, 8'h20);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (deq != '0) cnt++;
    end
    chk("bp_single_pulse", cnt, 0);

    do_reset();
    vld = 8'h08; set_q(3, 200); set_q(5, 100); set_len(3, 40); set_len(5, 40);
    @(negedge clk); #1;
    chk("empty_def3_loaded", dut.deficit[3], 200);
    chk("empty_ptr3", dut.ptr, 3);
    vld = 8'h20;
    @(negedge clk); #1;
    chk("empty_def3_cleared", dut.deficit[3], 0);
    chk("empty_ptr5", dut.ptr, 5);
    chk("empty_def5", dut.deficit[5], 100);

    do_reset();
    vld = 8'h04; set_q(2, 50); set_len(2, 33);
    @(negedge clk);
    @(negedge clk); #1;
    chk("arst_offer_vld", {ovld, otc}, {1'b1, 3'd2});
    rdy = 1'b1;
    #1;
    chk("arst_pre_deq", deq, 8'h04);
    arst = 1'b1;
    #1;
    chk("arst_vld_drop", ovld, 0);
    chk("arst_deq_drop", deq, 0);
    @(negedge clk);
    vld = '0;
    arst = 1'b0;
    #1;
    chk("arst_ptr", dut.ptr, 0);
    for (int i = 0; i < N; i++) chk($sformatf("arst_def%0d", i), dut.deficit[i], 0);

    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      sp = (ph == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
      for (int i = 0; i < N; i++) set_q(i, ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 600));
      for (int c = 0; c < 300; c++) begin
        vld  = 8'($urandom) | 8'($urandom);
        xoff = 8'($urandom) & 8'($urandom) & 8'($urandom);
        rdy  = ($urandom_range(0, 2) != 0);
        for (int i = 0; i < N; i++) set_len(i, $urandom_range(1, 1500));
        #1;
        ex = {6'd0, m_off, 3'(m_tc), 14'(m_len), (m_off && rdy) ? 8'(1 << m_tc) : 8'h00};
        chk("rand_outputs", {6'd0, ovld, otc, olen, deq}, ex);
        model_step();
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
